// File: rtl/snake_pkg.sv
// Shared types and initial-snake constants for the snake game datapath.
package snake_pkg;

    typedef enum logic [1:0] {
        UP    = 2'd0,
        DOWN  = 2'd1,
        LEFT  = 2'd2,
        RIGHT = 2'd3
    } DIRECTION;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_DEAD = 1'b1
    } state_t;

    localparam int INIT_LEN = 3;
    localparam int INIT_X   = 4;
    localparam int INIT_Y   = 6;

    // Initial body lies horizontally, head at (INIT_X, INIT_Y) pointing right.
    function automatic int init_x(input int idx);
        return (idx < INIT_LEN) ? (INIT_X - idx) : 0;
    endfunction

    function automatic int init_y(input int idx);
        return (idx < INIT_LEN) ? INIT_Y : 0;
    endfunction

endpackage

// File: rtl/snake_next_head.sv
// Combinational next-head step with wall detection; no wrap-around.
module snake_next_head
    import snake_pkg::*;
#(
    parameter int GRID_W = 16,
    parameter int GRID_H = 12,
    parameter int XW     = $clog2(GRID_W),
    parameter int YW     = $clog2(GRID_H)
) (
    input  logic [XW-1:0] head_x,
    input  logic [YW-1:0] head_y,
    input  logic [1:0]    direction,
    output logic [XW-1:0] next_x,
    output logic [YW-1:0] next_y,
    output logic          wall_hit
);

    // On a wall hit the head is left unchanged; callers must not use it.
    always_comb begin
        next_x   = head_x;
        next_y   = head_y;
        wall_hit = 1'b0;
        case (direction)
            UP:    if (head_y == '0) wall_hit = 1'b1;
                   else next_y = head_y - YW'(1);
            DOWN:  if (head_y == YW'(GRID_H - 1)) wall_hit = 1'b1;
                   else next_y = head_y + YW'(1);
            LEFT:  if (head_x == '0) wall_hit = 1'b1;
                   else next_x = head_x - XW'(1);
            default: if (head_x == XW'(GRID_W - 1)) wall_hit = 1'b1;
                     else next_x = head_x + XW'(1);
        endcase
    end

endmodule

// File: rtl/snake_body_tracker.sv
// Snake body register array: advances the head on move ticks, grows on apples,
// and flags wall/self collisions.
//   state   | meaning
//   ST_RUN  | snake moves on each move_tick
//   ST_DEAD | collided; move ticks ignored until restart
module snake_body_tracker
    import snake_pkg::*;
#(
    parameter int GRID_W     = 16,
    parameter int GRID_H     = 12,
    parameter int MAX_LENGTH = 16,
    localparam int XW = $clog2(GRID_W),
    localparam int YW = $clog2(GRID_H),
    localparam int LW = $clog2(MAX_LENGTH + 1)
) (
    input  logic                     clk,
    input  logic                     nrst,
    input  logic                     move_tick,
    input  logic [1:0]               direction,
    input  logic                     restart,
    input  logic [XW-1:0]            apple_x,
    input  logic [YW-1:0]            apple_y,
    output logic [MAX_LENGTH*XW-1:0] body_x,
    output logic [MAX_LENGTH*YW-1:0] body_y,
    output logic [LW-1:0]            length,
    output logic                     ate_apple,
    output logic                     bad_collision,
    output logic                     alive
);

    logic [XW-1:0] seg_x [MAX_LENGTH];
    logic [YW-1:0] seg_y [MAX_LENGTH];
    logic [LW-1:0] len_q;
    state_t        state;

    logic [XW-1:0] next_x;
    logic [YW-1:0] next_y;
    logic          wall_hit;
    logic          grow;
    logic          self_hit;

    snake_next_head #(
        .GRID_W (GRID_W),
        .GRID_H (GRID_H),
        .XW     (XW),
        .YW     (YW)
    ) u_next_head (
        .head_x    (seg_x[0]),
        .head_y    (seg_y[0]),
        .direction (direction),
        .next_x    (next_x),
        .next_y    (next_y),
        .wall_hit  (wall_hit)
    );

    assign grow = !wall_hit && (next_x == apple_x) && (next_y == apple_y);

    // The tail cell is free to enter unless this move grows the snake.
    always_comb begin
        self_hit = 1'b0;
        for (int i = 1; i < MAX_LENGTH; i++) begin
            if ((LW'(i) < len_q) && ((LW'(i) != len_q - LW'(1)) || grow) &&
                (seg_x[i] == next_x) && (seg_y[i] == next_y))
                self_hit = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < MAX_LENGTH; i++) begin
                seg_x[i] <= XW'(init_x(i));
                seg_y[i] <= YW'(init_y(i));
            end
            len_q         <= LW'(INIT_LEN);
            state         <= ST_RUN;
            ate_apple     <= 1'b0;
            bad_collision <= 1'b0;
        end else begin
            ate_apple     <= 1'b0;
            bad_collision <= 1'b0;
            if (restart) begin
                for (int i = 0; i < MAX_LENGTH; i++) begin
                    seg_x[i] <= XW'(init_x(i));
                    seg_y[i] <= YW'(init_y(i));
                end
                len_q <= LW'(INIT_LEN);
                state <= ST_RUN;
            end else if (move_tick && (state == ST_RUN)) begin
                if (wall_hit || self_hit) begin
                    bad_collision <= 1'b1;
                    state         <= ST_DEAD;
                end else begin
                    for (int i = MAX_LENGTH - 1; i > 0; i--) begin
                        seg_x[i] <= seg_x[i-1];
                        seg_y[i] <= seg_y[i-1];
                    end
                    seg_x[0] <= next_x;
                    seg_y[0] <= next_y;
                    if (grow) begin
                        ate_apple <= 1'b1;
                        if (len_q != LW'(MAX_LENGTH))
                            len_q <= len_q + LW'(1);
                    end
                end
            end
        end
    end

    for (genvar g = 0; g < MAX_LENGTH; g++) begin : g_pack
        assign body_x[g*XW +: XW] = seg_x[g];
        assign body_y[g*YW +: YW] = seg_y[g];
    end

    assign length = len_q;
    assign alive  = (state == ST_RUN);

endmodule

// File: tb/tb_snake_body_tracker.sv
// Directed bench for snake_body_tracker: moves, growth, collisions, restart, reset.
module tb_snake_body_tracker;
    import snake_pkg::*;

    logic        clk;
    logic        nrst;
    logic        move_tick;
    logic [1:0]  direction;
    logic        restart;
    logic [3:0]  apple_x;
    logic [3:0]  apple_y;
    logic [63:0] body_x;
    logic [63:0] body_y;
    logic [4:0]  length;
    logic        ate_apple;
    logic        bad_collision;
    logic        alive;

    int tests_run = 0;
    int tests_failed = 0;

    snake_body_tracker #(
        .GRID_W     (16),
        .GRID_H     (12),
        .MAX_LENGTH (16)
    ) dut (
        .clk           (clk),
        .nrst          (nrst),
        .move_tick     (move_tick),
        .direction     (direction),
        .restart       (restart),
        .apple_x       (apple_x),
        .apple_y       (apple_y),
        .body_x        (body_x),
        .body_y        (body_y),
        .length        (length),
        .ate_apple     (ate_apple),
        .bad_collision (bad_collision),
        .alive         (alive)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] sx(input int i);
        return body_x[i*4 +: 4];
    endfunction

    function automatic logic [3:0] sy(input int i);
        return body_y[i*4 +: 4];
    endfunction

    task automatic tick(input logic [1:0] d);
        @(negedge clk);
        direction = d;
        move_tick = 1'b1;
        @(negedge clk);
        move_tick = 1'b0;
    endtask

    task automatic pulse_restart();
        @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        nrst = 1'b0;
        @(negedge clk);
        nrst = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        nrst = 1'b0;
        #2;
        tests_run++;
        if ({length, alive, ate_apple, bad_collision} !== {5'd3, 1'b1, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got len=%0d alive=%b ate=%b bad=%b, expected 3 1 0 0",
                     length, alive, ate_apple, bad_collision);
        end
        tests_run++;
        if ({sx(0), sy(0), sx(1), sy(1), sx(2), sy(2), sx(3), sy(3), sx(15), sy(15)} !==
            {4'd4, 4'd6, 4'd3, 4'd6, 4'd2, 4'd6, 4'd0, 4'd0, 4'd0, 4'd0}) begin
            tests_failed++;
            $display("FAIL reset_body: got (%0d,%0d) (%0d,%0d) (%0d,%0d) (%0d,%0d), expected (4,6) (3,6) (2,6) (0,0)",
                     sx(0), sy(0), sx(1), sy(1), sx(2), sy(2), sx(3), sy(3));
        end
        @(negedge clk);
        nrst = 1'b1;
    endtask

    task automatic test_move_right();
        tick(RIGHT);
        tick(RIGHT);
        tick(RIGHT);
        tests_run++;
        if ({sx(0), sy(0), sx(1), sy(1), sx(2), sy(2), length, ate_apple, bad_collision} !==
            {4'd7, 4'd6, 4'd6, 4'd6, 4'd5, 4'd6, 5'd3, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL move_right: got head (%0d,%0d) s1 (%0d,%0d) s2 (%0d,%0d) len=%0d ate=%b bad=%b, expected (7,6) (6,6) (5,6) 3 0 0",
                     sx(0), sy(0), sx(1), sy(1), sx(2), sy(2), length, ate_apple, bad_collision);
        end
    endtask

    task automatic test_eat();
        do_reset();
        apple_x = 4'd5;
        apple_y = 4'd6;
        tick(RIGHT);
        tests_run++;
        if ({sx(0), sy(0), sx(3), sy(3), length, ate_apple} !== {4'd5, 4'd6, 4'd2, 4'd6, 5'd4, 1'b1}) begin
            tests_failed++;
            $display("FAIL eat: got head (%0d,%0d) tail (%0d,%0d) len=%0d ate=%b, expected (5,6) (2,6) 4 1",
                     sx(0), sy(0), sx(3), sy(3), length, ate_apple);
        end
        apple_x = 4'd0;
        apple_y = 4'd11;
        @(negedge clk);
        tests_run++;
        if ({ate_apple, length} !== {1'b0, 5'd4}) begin
            tests_failed++;
            $display("FAIL eat_pulse_width: got ate=%b len=%0d, expected 0 4", ate_apple, length);
        end
    endtask

    task automatic test_wall();
        for (int i = 0; i < 10; i++) tick(RIGHT);
        tests_run++;
        if ({sx(0), sy(0), alive, bad_collision} !== {4'd15, 4'd6, 1'b1, 1'b0}) begin
            tests_failed++;
            $display("FAIL wall_approach: got head (%0d,%0d) alive=%b bad=%b, expected (15,6) 1 0",
                     sx(0), sy(0), alive, bad_collision);
        end
        tick(RIGHT);
        tests_run++;
        if ({bad_collision, alive, ate_apple, sx(0), sy(0), sx(1), length} !==
            {1'b1, 1'b0, 1'b0, 4'd15, 4'd6, 4'd14, 5'd4}) begin
            tests_failed++;
            $display("FAIL wall_hit: got bad=%b alive=%b ate=%b head (%0d,%0d) s1x=%0d len=%0d, expected 1 0 0 (15,6) 14 4",
                     bad_collision, alive, ate_apple, sx(0), sy(0), sx(1), length);
        end
        tick(UP);
        tests_run++;
        if ({bad_collision, alive, sx(0), sy(0), length} !== {1'b0, 1'b0, 4'd15, 4'd6, 5'd4}) begin
            tests_failed++;
            $display("FAIL dead_ignore: got bad=%b alive=%b head (%0d,%0d) len=%0d, expected 0 0 (15,6) 4",
                     bad_collision, alive, sx(0), sy(0), length);
        end
    endtask

    task automatic build_coil4();
        pulse_restart();
        apple_x = 4'd4;
        apple_y = 4'd5;
        tick(UP);
        apple_x = 4'd0;
        apple_y = 4'd11;
        tick(RIGHT);
        tick(DOWN);
    endtask

    task automatic test_self_collision();
        build_coil4();
        tests_run++;
        if ({alive, length, sx(0), sy(0), sx(3), sy(3)} !== {1'b1, 5'd4, 4'd5, 4'd6, 4'd4, 4'd6}) begin
            tests_failed++;
            $display("FAIL coil4_setup: got alive=%b len=%0d head (%0d,%0d) tail (%0d,%0d), expected 1 4 (5,6) (4,6)",
                     alive, length, sx(0), sy(0), sx(3), sy(3));
        end
        tick(LEFT);
        tests_run++;
        if ({bad_collision, alive, sx(0), sy(0), sx(3), sy(3)} !== {1'b0, 1'b1, 4'd4, 4'd6, 4'd4, 4'd5}) begin
            tests_failed++;
            $display("FAIL tail_chase: got bad=%b alive=%b head (%0d,%0d) tail (%0d,%0d), expected 0 1 (4,6) (4,5)",
                     bad_collision, alive, sx(0), sy(0), sx(3), sy(3));
        end
        build_coil4();
        apple_x = 4'd4;
        apple_y = 4'd6;
        tick(LEFT);
        tests_run++;
        if ({bad_collision, alive, ate_apple, length, sx(0)} !== {1'b1, 1'b0, 1'b0, 5'd4, 4'd5}) begin
            tests_failed++;
            $display("FAIL tail_grow_hit: got bad=%b alive=%b ate=%b len=%0d headx=%0d, expected 1 0 0 4 5",
                     bad_collision, alive, ate_apple, length, sx(0));
        end
        pulse_restart();
        tests_run++;
        if ({alive, length, sx(0), sy(0)} !== {1'b1, 5'd3, 4'd4, 4'd6}) begin
            tests_failed++;
            $display("FAIL restart_from_dead: got alive=%b len=%0d head (%0d,%0d), expected 1 3 (4,6)",
                     alive, length, sx(0), sy(0));
        end
        apple_x = 4'd4;
        apple_y = 4'd5;
        tick(UP);
        apple_x = 4'd5;
        apple_y = 4'd5;
        tick(RIGHT);
        apple_x = 4'd0;
        apple_y = 4'd11;
        tick(DOWN);
        tick(LEFT);
        tests_run++;
        if ({bad_collision, alive, length, sx(0), sy(0)} !== {1'b1, 1'b0, 5'd5, 4'd5, 4'd6}) begin
            tests_failed++;
            $display("FAIL body_hit_len5: got bad=%b alive=%b len=%0d head (%0d,%0d), expected 1 0 5 (5,6)",
                     bad_collision, alive, length, sx(0), sy(0));
        end
    endtask

    task automatic test_max_length();
        pulse_restart();
        for (int x = 5; x <= 15; x++) begin
            apple_x = 4'(x);
            apple_y = 4'd6;
            tick(RIGHT);
        end
        apple_x = 4'd15;
        apple_y = 4'd5;
        tick(UP);
        apple_y = 4'd4;
        tick(UP);
        tests_run++;
        if ({length, alive, sx(15), sy(15)} !== {5'd16, 1'b1, 4'd2, 4'd6}) begin
            tests_failed++;
            $display("FAIL grow_to_max: got len=%0d alive=%b tail (%0d,%0d), expected 16 1 (2,6)",
                     length, alive, sx(15), sy(15));
        end
        apple_y = 4'd3;
        tick(UP);
        tests_run++;
        if ({ate_apple, length, sx(0), sy(0), sx(15), sy(15)} !== {1'b1, 5'd16, 4'd15, 4'd3, 4'd3, 4'd6}) begin
            tests_failed++;
            $display("FAIL eat_at_max: got ate=%b len=%0d head (%0d,%0d) tail (%0d,%0d), expected 1 16 (15,3) (3,6)",
                     ate_apple, length, sx(0), sy(0), sx(15), sy(15));
        end
        apple_x = 4'd5;
        apple_y = 4'd6;
        @(negedge clk);
        direction = RIGHT;
        move_tick = 1'b1;
        restart   = 1'b1;
        @(negedge clk);
        move_tick = 1'b0;
        restart   = 1'b0;
        tests_run++;
        if ({alive, length, ate_apple, bad_collision, sx(0), sy(0), sx(2), sx(3), sy(3)} !==
            {1'b1, 5'd3, 1'b0, 1'b0, 4'd4, 4'd6, 4'd2, 4'd0, 4'd0}) begin
            tests_failed++;
            $display("FAIL restart_wins: got alive=%b len=%0d ate=%b bad=%b head (%0d,%0d) s2x=%0d s3 (%0d,%0d), expected 1 3 0 0 (4,6) 2 (0,0)",
                     alive, length, ate_apple, bad_collision, sx(0), sy(0), sx(2), sx(3), sy(3));
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        apple_x = 4'd5;
        apple_y = 4'd6;
        @(negedge clk);
        direction = RIGHT;
        move_tick = 1'b1;
        @(posedge clk);
        #2;
        move_tick = 1'b0;
        tests_run++;
        if ({ate_apple, sx(0), length} !== {1'b1, 4'd5, 5'd4}) begin
            tests_failed++;
            $display("FAIL pre_reset_move: got ate=%b headx=%0d len=%0d, expected 1 5 4", ate_apple, sx(0), length);
        end
        nrst = 1'b0;
        #1;
        tests_run++;
        if ({ate_apple, bad_collision, alive, length, sx(0), sy(0), sx(3)} !==
            {1'b0, 1'b0, 1'b1, 5'd3, 4'd4, 4'd6, 4'd0}) begin
            tests_failed++;
            $display("FAIL async_reset: got ate=%b bad=%b alive=%b len=%0d head (%0d,%0d) s3x=%0d, expected 0 0 1 3 (4,6) 0",
                     ate_apple, bad_collision, alive, length, sx(0), sy(0), sx(3));
        end
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        direction = RIGHT;
        move_tick = 1'b1;
        #2;
        nrst = 1'b0;
        @(posedge clk);
        #1;
        move_tick = 1'b0;
        tests_run++;
        if ({ate_apple, length, sx(0)} !== {1'b0, 5'd3, 4'd4}) begin
            tests_failed++;
            $display("FAIL reset_aborts_move: got ate=%b len=%0d headx=%0d, expected 0 3 4", ate_apple, length, sx(0));
        end
        @(negedge clk);
        nrst = 1'b1;
    endtask

    initial begin
        nrst      = 1'b0;
        move_tick = 1'b0;
        direction = RIGHT;
        restart   = 1'b0;
        apple_x   = 4'd0;
        apple_y   = 4'd11;
        test_reset();
        test_move_right();
        test_eat();
        test_wall();
        test_self_collision();
        test_max_length();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/snake_body_tracker.md
# snake_body_tracker

Downstream consumer of the direction register: on each movement tick it advances the snake head one cell in the current direction and shifts the body segment array. It detects wall and self collisions, grows the snake when the head lands on the apple, and issues the `bad_collision` pulse that resets the direction stage. Its registered segment array feeds the display renderer and the apple generator.

## Interface
Parameters:
- `GRID_W`, 16: grid columns; x range 0..GRID_W-1.
- `GRID_H`, 12: grid rows; y range 0..GRID_H-1.
- `MAX_LENGTH`, 16: segment capacity; must be ≥ 4.
- Derived: `XW = $clog2(GRID_W)`, `YW = $clog2(GRID_H)`, `LW = $clog2(MAX_LENGTH+1)`.

Ports:
- `clk`  in  1  clock.
- `nrst`  in  1  reset, asynchronous, active-low.
- `move_tick`  in  1  one-cycle move strobe; same strobe that loads the direction register.
- `direction`  in  2  `DIRECTION` value from the direction stage.
- `restart`  in  1  one-cycle pulse; re-initialises the snake from DEAD or RUN.
- `apple_x`  in  XW  current apple column.
- `apple_y`  in  YW  current apple row.
- `body_x`  out  MAX_LENGTH*XW  segment x coordinates; segment 0 (head) in the LSBs.
- `body_y`  out  MAX_LENGTH*YW  segment y coordinates; same packing.
- `length`  out  LW  number of valid segments, starting at segment 0.
- `ate_apple`  out  1  one-cycle pulse when the head lands on the apple.
- `bad_collision`  out  1  one-cycle pulse on a wall or self hit.
- `alive`  out  1  high in RUN, low in DEAD.

## Operation
- States: RUN and DEAD.
  - Reset → RUN with the initial snake.
  - RUN → DEAD on collision.
  - DEAD → RUN on `restart`, with the initial snake.
  - `restart` in RUN also re-initialises the snake.
- Initial snake: `length=3`; segments (4,6), (3,6), (2,6); every other segment is (0,0).
- Next-head computation, from segment 0:
  - UP: y-1. DOWN: y+1. LEFT: x-1. RIGHT: x+1.
  - No wrap-around.
  - Wall hit: UP with y=0, DOWN with y=GRID_H-1, LEFT with x=0, or RIGHT with x=GRID_W-1.
- `grow` = next head equals (apple_x, apple_y).
- Self hit: next head equals segment i for i in 1..length-1.
  - The tail (i=length-1) is excluded when `grow=0`, because the tail vacates that cell.
  - Segments at index ≥ length are never compared.
- On `move_tick` in RUN with no collision:
  - segment[i] ← segment[i-1] for i ≥ 1.
  - segment[0] ← next head.
  - If `grow`: `length` ← min(length+1, MAX_LENGTH) and `ate_apple` pulses.
  - At MAX_LENGTH, `ate_apple` still pulses, `length` holds, and the tail drops.
- On `move_tick` in RUN with a collision:
  - Segments and length freeze.
  - `bad_collision` pulses.
  - State → DEAD.
  - Wall hit takes precedence over `grow`; no `ate_apple` pulse.
- `move_tick` in DEAD is ignored.
- Same-cycle `restart` and `move_tick`: `restart` wins and no move occurs.

## Timing
- Reset values: initial snake, `length=3`, `alive=1`, `ate_apple=0`, `bad_collision=0`.
- All outputs are registered.
- Effects of `move_tick` sampled at edge N are visible after edge N: body, length and pulses change together, 1-cycle latency.
- Pulses last exactly one cycle and never repeat without a new `move_tick`.
- Effects of `restart` are visible after the next edge.
- `direction` and apple inputs are sampled only in the `move_tick` cycle.
- `nrst` mid-move aborts the move immediately and restores the reset values.

## Structure
- Shared package `snake_pkg` holds:
  - `typedef enum logic [1:0] DIRECTION` with UP=0, DOWN=1, LEFT=2, RIGHT=3.
  - The state enum.
  - The initial-snake constants `INIT_LEN`, `INIT_X`, `INIT_Y`.
- Sub-module `snake_next_head` (combinational): takes the head, direction and grid bounds; outputs the next head and `wall_hit`.
- Top level holds the segment array, the self-compare loop, the length counter and the FSM.

## Test plan
- Reset, then 3 ticks RIGHT → head (7,6), segments (6,6), (5,6); length 3; no pulses.
- Apple at (5,6), one tick RIGHT → head (5,6), length 4, `ate_apple` high for exactly 1 cycle, tail (2,6) retained.
- Head at (15,6), tick RIGHT → `bad_collision` for 1 cycle, `alive=0`, body frozen; further ticks cause no change.
- Length 4 coiled so the next head equals the tail cell, no apple → legal move with no collision. Same geometry at length 5, where the target cell is not the tail → self hit.
- Length at MAX_LENGTH, eat apple → `ate_apple` pulses, `length` stays 16. Then `restart` together with `move_tick` → initial snake, `alive=1`, no move.
- Assert `nrst` in the cycle after a `move_tick` → all outputs return to reset values immediately, asynchronously.
